// File: rtl/keypoint_stream_tx_if.sv
// Byte stream from the keypoint streamer to the UART transmitter.
// A byte moves on a clk edge where tx_valid_out and tx_ready_in are both 1;
// while tx_valid_out is 1 and not yet accepted, tx_data_out holds still and
// tx_valid_out stays high.
interface keypoint_stream_tx_if;
   logic [7:0] tx_data_out;
   logic       tx_valid_out;
   logic       tx_ready_in;

   modport master (output tx_data_out, output tx_valid_out, input tx_ready_in);
   modport slave  (input tx_data_out, input tx_valid_out, output tx_ready_in);
endinterface

// File: rtl/keypoint_stream_tx.sv
// Streams NUM_CHANNELS BRAM regions as framed byte packets:
//   SYNC_BYTE, channel id, payload (each word MSB byte first), COUNT[15:8], COUNT[7:0]
// An all-zero word may end a channel early (TERMINATE_ON_ZERO); it is not sent.
module keypoint_stream_tx #(
   parameter int         BRAM_LENGTH       = 1000,
   parameter int         DATA_WIDTH        = 13,
   parameter int         NUM_CHANNELS      = 3,
   parameter int         BRAM_LATENCY      = 2,
   parameter logic [7:0] SYNC_BYTE         = 8'hA5,
   parameter bit         TERMINATE_ON_ZERO = 1'b1,
   localparam int        AW = (BRAM_LENGTH > 1) ? $clog2(BRAM_LENGTH) : 1,
   localparam int        CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_in,
   input  logic                  start_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [AW-1:0]         address_out,
   output logic [CW-1:0]         channel_out,
   keypoint_stream_tx_if.master  tx,
   output logic                  busy_out,
   output logic                  done_out,
   output logic [2:0]            state_out
);

   localparam int NB = (DATA_WIDTH + 7) / 8;
   localparam int SW = NB * 8;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam int LW = ($clog2(BRAM_LATENCY + 1) > 0) ? $clog2(BRAM_LATENCY + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_CHID, S_FETCH, S_WORD, S_CNT_HI, S_CNT_LO, S_NEXT
   } state_t;

   state_t        state;
   logic [15:0]   count;
   logic [15:0]   count_inc;
   logic [LW-1:0] lat_cnt;
   logic [IW-1:0] idx;
   logic [SW-1:0] sr;
   logic [SW-1:0] word_ext;
   int            idx_int;

   assign state_out = state;

   // Zero-extended BRAM word and helpers for the byte walk.
   always_comb begin
      word_ext  = SW'(data_in);
      count_inc = count + 16'd1;
      idx_int   = int'(idx);
   end

   // Stream FSM; every output is registered here. Address and channel only
   // move in IDLE, WORD and NEXT so BRAM data is stable through FETCH.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         state           <= S_IDLE;
         address_out     <= '0;
         channel_out     <= '0;
         tx.tx_data_out  <= '0;
         tx.tx_valid_out <= 1'b0;
         busy_out        <= 1'b0;
         done_out        <= 1'b0;
         count           <= '0;
         lat_cnt         <= '0;
         idx             <= '0;
         sr              <= '0;
      end else begin
         done_out <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_in) begin
                  state           <= S_SYNC;
                  busy_out        <= 1'b1;
                  channel_out     <= '0;
                  address_out     <= '0;
                  count           <= '0;
                  tx.tx_data_out  <= SYNC_BYTE;
                  tx.tx_valid_out <= 1'b1;
               end
            end
            S_SYNC: begin
               if (tx.tx_ready_in) begin
                  state          <= S_CHID;
                  tx.tx_data_out <= 8'(channel_out);
               end
            end
            S_CHID: begin
               if (tx.tx_ready_in) begin
                  state           <= S_FETCH;
                  tx.tx_valid_out <= 1'b0;
                  lat_cnt         <= '0;
               end
            end
            S_FETCH: begin
               if (lat_cnt == LW'(BRAM_LATENCY)) begin
                  tx.tx_valid_out <= 1'b1;
                  if (TERMINATE_ON_ZERO && (data_in == '0)) begin
                     state          <= S_CNT_HI;
                     tx.tx_data_out <= count[15:8];
                  end else begin
                     state          <= S_WORD;
                     sr             <= word_ext;
                     tx.tx_data_out <= word_ext[SW-1 -: 8];
                     idx            <= IW'(NB - 1);
                  end
               end else begin
                  lat_cnt <= lat_cnt + LW'(1);
               end
            end
            S_WORD: begin
               if (tx.tx_ready_in) begin
                  if (idx != '0) begin
                     idx            <= idx - IW'(1);
                     tx.tx_data_out <= sr[(idx_int - 1) * 8 +: 8];
                  end else begin
                     count <= count_inc;
                     if (address_out == AW'(BRAM_LENGTH - 1)) begin
                        state          <= S_CNT_HI;
                        tx.tx_data_out <= count_inc[15:8];
                     end else begin
                        state           <= S_FETCH;
                        address_out     <= address_out + AW'(1);
                        tx.tx_valid_out <= 1'b0;
                        lat_cnt         <= '0;
                     end
                  end
               end
            end
            S_CNT_HI: begin
               if (tx.tx_ready_in) begin
                  state          <= S_CNT_LO;
                  tx.tx_data_out <= count[7:0];
               end
            end
            S_CNT_LO: begin
               if (tx.tx_ready_in) begin
                  state           <= S_NEXT;
                  tx.tx_valid_out <= 1'b0;
               end
            end
            S_NEXT: begin
               count       <= '0;
               address_out <= '0;
               if (channel_out == CW'(NUM_CHANNELS - 1)) begin
                  state    <= S_IDLE;
                  busy_out <= 1'b0;
                  done_out <= 1'b1;
               end else begin
                  state           <= S_SYNC;
                  channel_out     <= channel_out + CW'(1);
                  tx.tx_data_out  <= SYNC_BYTE;
                  tx.tx_valid_out <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypoint_stream_tx.sv
// Bench for keypoint_stream_tx: four configurations side by side
//   0: W=13 L=4 C=1 T0=0 LAT=2   1: W=13 L=4 C=2 T0=1 LAT=3
//   2: W=20 L=2 C=1 T0=1 LAT=1   3: W=8  L=3 C=1 T0=1 LAT=2
module tb_keypoint_stream_tx;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst[4], start[4], ready[4];

   // ---------------- per-instance configuration ----------------
   int p_w[4] = '{13, 13, 20, 8};
   int p_l[4] = '{4, 4, 2, 3};
   int p_c[4] = '{1, 2, 1, 1};
   bit p_t[4] = '{1'b0, 1'b1, 1'b1, 1'b1};

   // ---------------- DUT wiring ----------------
   keypoint_stream_tx_if if0 (), if1 (), if2 (), if3 ();
   logic [12:0] din0, din1;
   logic [19:0] din2;
   logic [7:0]  din3;
   logic [1:0]  a0, a1, a3;
   logic [0:0]  a2;
   logic        c0, c1, c2, c3;
   logic        bsy0, bsy1, bsy2, bsy3, dn0, dn1, dn2, dn3;
   logic [2:0]  st0, st1, st2, st3;

   logic [1:0]  addr_w[4];
   logic        ch_w[4], busy_w[4], done_w[4], valid_w[4];
   logic [7:0]  data_w[4];

   assign if0.tx_ready_in = ready[0];
   assign if1.tx_ready_in = ready[1];
   assign if2.tx_ready_in = ready[2];
   assign if3.tx_ready_in = ready[3];
   assign addr_w[0] = a0; assign addr_w[1] = a1; assign addr_w[2] = {1'b0, a2}; assign addr_w[3] = a3;
   assign ch_w[0] = c0; assign ch_w[1] = c1; assign ch_w[2] = c2; assign ch_w[3] = c3;
   assign busy_w[0] = bsy0; assign busy_w[1] = bsy1; assign busy_w[2] = bsy2; assign busy_w[3] = bsy3;
   assign done_w[0] = dn0; assign done_w[1] = dn1; assign done_w[2] = dn2; assign done_w[3] = dn3;
   assign valid_w[0] = if0.tx_valid_out; assign valid_w[1] = if1.tx_valid_out;
   assign valid_w[2] = if2.tx_valid_out; assign valid_w[3] = if3.tx_valid_out;
   assign data_w[0] = if0.tx_data_out; assign data_w[1] = if1.tx_data_out;
   assign data_w[2] = if2.tx_data_out; assign data_w[3] = if3.tx_data_out;

   keypoint_stream_tx #(.BRAM_LENGTH(4), .DATA_WIDTH(13), .NUM_CHANNELS(1), .BRAM_LATENCY(2),
      .SYNC_BYTE(8'hA5), .TERMINATE_ON_ZERO(1'b0)) dut0 (
      .clk(clk), .rst_in(rst[0]), .start_in(start[0]), .data_in(din0), .address_out(a0),
      .channel_out(c0), .tx(if0), .busy_out(bsy0), .done_out(dn0), .state_out(st0));
   keypoint_stream_tx #(.BRAM_LENGTH(4), .DATA_WIDTH(13), .NUM_CHANNELS(2), .BRAM_LATENCY(3),
      .SYNC_BYTE(8'hA5), .TERMINATE_ON_ZERO(1'b1)) dut1 (
      .clk(clk), .rst_in(rst[1]), .start_in(start[1]), .data_in(din1), .address_out(a1),
      .channel_out(c1), .tx(if1), .busy_out(bsy1), .done_out(dn1), .state_out(st1));
   keypoint_stream_tx #(.BRAM_LENGTH(2), .DATA_WIDTH(20), .NUM_CHANNELS(1), .BRAM_LATENCY(1),
      .SYNC_BYTE(8'hA5), .TERMINATE_ON_ZERO(1'b1)) dut2 (
      .clk(clk), .rst_in(rst[2]), .start_in(start[2]), .data_in(din2), .address_out(a2),
      .channel_out(c2), .tx(if2), .busy_out(bsy2), .done_out(dn2), .state_out(st2));
   keypoint_stream_tx #(.BRAM_LENGTH(3), .DATA_WIDTH(8), .NUM_CHANNELS(1), .BRAM_LATENCY(2),
      .SYNC_BYTE(8'hA5), .TERMINATE_ON_ZERO(1'b1)) dut3 (
      .clk(clk), .rst_in(rst[3]), .start_in(start[3]), .data_in(din3), .address_out(a3),
      .channel_out(c3), .tx(if3), .busy_out(bsy3), .done_out(dn3), .state_out(st3));

   // ---------------- BRAM model: shared contents, per-instance read pipeline ----------------
   logic [19:0] mem [2][4];
   logic [19:0] pipe [4][3];

   always @(posedge clk)
      for (int k = 0; k < 4; k++) begin
         pipe[k][0] <= mem[ch_w[k]][addr_w[k]];
         pipe[k][1] <= pipe[k][0];
         pipe[k][2] <= pipe[k][1];
      end

   assign din0 = pipe[0][1][12:0];
   assign din1 = pipe[1][2][12:0];
   assign din2 = pipe[2][0];
   assign din3 = pipe[3][1][7:0];

   // ---------------- monitor: capture accepted bytes, watch hold-while-stalled ----------------
   logic [7:0] cap_q[$];
   logic [7:0] exp_q[$];
   logic       pv[4], pr[4];
   logic [7:0] pd[4];
   int         stab_err = 0;

   always @(posedge clk)
      for (int k = 0; k < 4; k++) begin
         if (!rst[k] && valid_w[k] && ready[k]) cap_q.push_back(data_w[k]);
         if (!rst[k] && pv[k] && !pr[k] && (!valid_w[k] || data_w[k] != pd[k])) stab_err++;
         pv[k] <= valid_w[k];
         pr[k] <= ready[k];
         pd[k] <= data_w[k];
      end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic compare_stream(input string name);
      check({name, " length"}, cap_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
         check($sformatf("%s byte%0d", name, i), 32'(cap_q[i]), 32'(exp_q[i]));
   endtask

   // Reference: packet stream computed directly from the framing rules.
   function automatic void build_expected(input int k);
      int nb;
      int cnt;
      logic [19:0] w;
      nb = (p_w[k] + 7) / 8;
      exp_q.delete();
      for (int c = 0; c < p_c[k]; c++) begin
         exp_q.push_back(8'hA5);
         exp_q.push_back(8'(c));
         cnt = 0;
         for (int a = 0; a < p_l[k]; a++) begin
            w = mem[c][a];
            if (p_t[k] && w == 20'd0) break;
            for (int b = nb - 1; b >= 0; b--) exp_q.push_back(8'(w >> (8 * b)));
            cnt++;
         end
         exp_q.push_back(8'(cnt >> 8));
         exp_q.push_back(8'(cnt));
      end
   endfunction

   // ---------------- driver ----------------
   // Called at a negedge. n_passes>1 holds start until the follow-on pass is seen.
   task automatic run_pass(input int k, input int rdy_pct, input int n_passes,
                           input int mid_pulse_at, input string name);
      int cyc, dones, done_cyc;
      bit hold;
      cyc = 0; dones = 0; done_cyc = 0;
      hold = (n_passes > 1);
      cap_q.delete();
      start[k] = 1'b1;
      @(negedge clk);
      check({name, " busy after start"}, 32'(busy_w[k]), 32'd1);
      if (!hold) start[k] = 1'b0;
      while (dones < n_passes && cyc < 3000) begin
         ready[k] = ($urandom_range(99) < rdy_pct);
         if (cyc == mid_pulse_at) start[k] = 1'b1;
         else if (!hold) start[k] = 1'b0;
         @(negedge clk);
         cyc++;
         if (done_w[k]) begin
            dones++;
            done_cyc = cyc;
            check({name, " busy low at done"}, 32'(busy_w[k]), 32'd0);
         end else if (hold && start[k] && dones == n_passes - 1 && dones > 0 && busy_w[k]) begin
            start[k] = 1'b0;
            check({name, " back-to-back gap"}, 32'(cyc - done_cyc), 32'd1);
         end
      end
      ready[k] = 1'b0;
      start[k] = 1'b0;
      check({name, " done count"}, 32'(dones), 32'(n_passes));
      @(negedge clk);
      check({name, " done one cycle"}, 32'(done_w[k]), 32'd0);
      check({name, " idle busy"}, 32'(busy_w[k]), 32'd0);
   endtask

   function automatic logic [159:0] mkw(input logic [19:0] a0w, a1w, a2w, a3w, b0w, b1w, b2w, b3w);
      return {b3w, b2w, b1w, b0w, a3w, a2w, a1w, a0w};
   endfunction

   task automatic load_words(input logic [159:0] words);
      for (int c = 0; c < 2; c++)
         for (int a = 0; a < 4; a++) mem[c][a] = words[(c * 4 + a) * 20 +: 20];
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int           inst;
      int           pct;
      logic [159:0] words;
      logic [191:0] eb;
      int           n;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int cyc;
      for (int k = 0; k < 4; k++) begin
         rst[k] = 1'b1; start[k] = 1'b0; ready[k] = 1'b0;
      end
      for (int c = 0; c < 2; c++)
         for (int a = 0; a < 4; a++) mem[c][a] = '0;

      tbl[0] = '{0, 100, mkw(20'h1234, 20'h0001, 20'h1FFF, 20'h0800, 0, 0, 0, 0),
                 192'(96'hA5_00_12_34_00_01_1F_FF_08_00_00_04), 12};
      tbl[1] = '{0, 30, mkw(20'h1234, 20'h0001, 20'h1FFF, 20'h0800, 0, 0, 0, 0),
                 192'(96'hA5_00_12_34_00_01_1F_FF_08_00_00_04), 12};
      tbl[2] = '{1, 100, mkw(20'h5, 20'h0, 20'h9, 20'h9, 20'h3, 20'h2, 20'h1, 20'h7),
                 192'(144'hA5_00_00_05_00_01_A5_01_00_03_00_02_00_01_00_07_00_04), 18};
      tbl[3] = '{2, 100, mkw(20'h0ABCDE, 20'h00001, 0, 0, 0, 0, 0, 0),
                 192'(80'hA5_00_0A_BC_DE_00_00_01_00_02), 10};
      tbl[4] = '{3, 100, mkw(20'h5A, 20'h01, 20'hFF, 0, 0, 0, 0, 0),
                 192'(56'hA5_00_5A_01_FF_00_03), 7};
      tbl[5] = '{1, 50, mkw(20'h0, 20'h5, 20'h5, 20'h5, 20'h1FFF, 20'h0, 20'h1, 20'h1),
                 192'(80'hA5_00_00_00_A5_01_1F_FF_00_01), 10};

      // Reset state of every instance.
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rst%0d valid", k), 32'(valid_w[k]), 32'd0);
         check($sformatf("rst%0d data", k),  32'(data_w[k]),  32'd0);
         check($sformatf("rst%0d busy", k),  32'(busy_w[k]),  32'd0);
         check($sformatf("rst%0d done", k),  32'(done_w[k]),  32'd0);
         check($sformatf("rst%0d addr", k),  32'(addr_w[k]),  32'd0);
         check($sformatf("rst%0d chan", k),  32'(ch_w[k]),    32'd0);
      end
      for (int k = 0; k < 4; k++) rst[k] = 1'b0;
      repeat (2) @(negedge clk);

      // Table-driven vectors.
      for (int r = 0; r < 6; r++) begin
         load_words(tbl[r].words);
         exp_q.delete();
         for (int j = 0; j < tbl[r].n; j++) exp_q.push_back(tbl[r].eb[(tbl[r].n - 1 - j) * 8 +: 8]);
         run_pass(tbl[r].inst, tbl[r].pct, 1, -1, $sformatf("vec%0d", r));
         compare_stream($sformatf("vec%0d", r));
      end

      // Start pulsed mid-pass is ignored.
      load_words(tbl[0].words);
      build_expected(0);
      run_pass(0, 60, 1, 6, "mid_start");
      compare_stream("mid_start");

      // Start held high: second pass follows immediately.
      build_expected(0);
      begin
         int n1;
         n1 = exp_q.size();
         for (int i = 0; i < n1; i++) exp_q.push_back(exp_q[i]);
      end
      run_pass(0, 100, 2, -1, "held_start");
      compare_stream("held_start");

      // Reset during a payload byte of channel 1.
      load_words(tbl[2].words);
      build_expected(1);
      cap_q.delete();
      start[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      ready[1] = 1'b1;
      cyc = 0;
      while (cap_q.size() < 9 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("mid_rst reached ch1 payload", 32'(cap_q.size()), 32'd9);
      check("mid_rst channel before", 32'(ch_w[1]), 32'd1);
      rst[1] = 1'b1;
      #1;
      check("mid_rst valid", 32'(valid_w[1]), 32'd0);
      check("mid_rst busy", 32'(busy_w[1]), 32'd0);
      check("mid_rst channel", 32'(ch_w[1]), 32'd0);
      check("mid_rst addr", 32'(addr_w[1]), 32'd0);
      ready[1] = 1'b0;
      @(negedge clk);
      rst[1] = 1'b0;
      @(negedge clk);
      run_pass(1, 100, 1, -1, "after_rst");
      compare_stream("after_rst");

      // Randomised contents and backpressure against the reference.
      for (int it = 0; it < 24; it++) begin
         int k;
         logic [19:0] w;
         k = it % 4;
         for (int c = 0; c < 2; c++)
            for (int a = 0; a < 4; a++) begin
               w = 20'($urandom) & 20'((1 << p_w[k]) - 1);
               if ($urandom_range(9) == 0) w = '0;
               mem[c][a] = w;
            end
         build_expected(k);
         run_pass(k, int'($urandom_range(100, 20)), 1, -1, $sformatf("rand%0d", it));
         compare_stream($sformatf("rand%0d", it));
      end

      check("stall hold violations", 32'(stab_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
